// File: rtl/acumulador_punto_fijo.sv
// Fixed-point dot-product accumulator: sums N_TERMS signed Q32.32 products,
// then rounds half-up and saturates the total to signed Q16.16.
//
// state  | meaning
// ACCUM  | accepting products into acc, counting terms
// ROUND  | one cycle: round/saturate acc, register the result
// OUTPUT | result held on out_data until the downstream takes it

module acumulador_punto_fijo #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 72
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-16){1'b0}}, 16'h8000};
    localparam logic signed [ACC_W-1:0] MAX_Q    = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_Q    = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        ROUND  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  term_ext;
    logic signed [ACC_W-1:0]  rnd;
    logic [CNT_W-1:0]         cnt;
    logic                     accept;
    logic                     last_term;
    logic [31:0]              sat_data;
    logic                     sat_flag;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUTPUT);
    assign accept    = in_ready && in_valid;
    assign last_term = (cnt == CNT_W'(N_TERMS - 1));
    assign term_ext  = {{(ACC_W-64){in_data[63]}}, in_data};

    // Q32.32 -> Q.16 with round half up; the headroom in acc keeps this exact.
    assign rnd = (acc + RND_HALF) >>> 16;

    always_comb begin
        sat_data = rnd[31:0];
        sat_flag = 1'b0;
        if (rnd > MAX_Q) begin
            sat_data = 32'h7FFF_FFFF;
            sat_flag = 1'b1;
        end else if (rnd < MIN_Q) begin
            sat_data = 32'h8000_0000;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && last_term) state_nxt = ROUND;
                ROUND:   state_nxt = OUTPUT;
                OUTPUT:  if (out_ready) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                acc <= acc + term_ext;
                cnt <= last_term ? '0 : cnt + 1'b1;
            end
            if (state == ROUND) begin
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end
            if (state == OUTPUT && out_ready) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_acumulador_punto_fijo.sv
// Directed bench for acumulador_punto_fijo (N_TERMS=4): exact results,
// rounding and saturation boundaries, backpressure, clear and reset.

module tb_acumulador_punto_fijo;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    int n_checks;
    int n_errors;

    localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
    localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] BIG_POS = 64'h0000_7FFF_0000_0000;
    localparam logic [63:0] BIG_NEG = 64'hFFFF_8000_0000_0000;

    acumulador_punto_fijo #(.N_TERMS(4), .ACC_W(72)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives four back-to-back terms; returns 1 time unit after the last accepting edge.
    task automatic feed4(input logic [63:0] t0, input logic [63:0] t1,
                         input logic [63:0] t2, input logic [63:0] t3);
        logic [63:0] terms [4];
        terms = '{t0, t1, t2, t3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = terms[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic run_sum(input string tag,
                           input logic [63:0] t0, input logic [63:0] t1,
                           input logic [63:0] t2, input logic [63:0] t3,
                           input logic [31:0] exp_d, input logic exp_s);
        feed4(t0, t1, t2, t3);
        check({tag, "_round_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_round_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp_d));
        check({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_sat", 64'(out_sat), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        run_sum("ones", ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);
        run_sum("rnd_half", 64'h8000, 64'h0, 64'h0, 64'h0, 32'h0000_0001, 1'b0);
        run_sum("rnd_below", 64'h7FFF, 64'h0, 64'h0, 64'h0, 32'h0000_0000, 1'b0);
        run_sum("rnd_neg_half", 64'hFFFF_FFFF_FFFF_8000, 64'h0, 64'h0, 64'h0, 32'h0000_0000, 1'b0);
        run_sum("rnd_neg_below", 64'hFFFF_FFFF_FFFF_7FFF, 64'h0, 64'h0, 64'h0, 32'hFFFF_FFFF, 1'b0);
        run_sum("neg_ones", NEG_ONE, NEG_ONE, NEG_ONE, NEG_ONE, 32'hFFFC_0000, 1'b0);
        // 1.5 - 0.25 + 2.0 - 3.0 = 0.25
        run_sum("mixed", 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_C000_0000,
                64'h0000_0002_0000_0000, 64'hFFFF_FFFD_0000_0000, 32'h0000_4000, 1'b0);
        run_sum("sat_pos", BIG_POS, BIG_POS, BIG_POS, BIG_POS, 32'h7FFF_FFFF, 1'b1);
        run_sum("sat_neg", BIG_NEG, BIG_NEG, BIG_NEG, BIG_NEG, 32'h8000_0000, 1'b1);

        // Backpressure: result held, junk inputs ignored, next sum starts at 0.
        feed4(ONE, ONE, ONE, 64'h0000_0002_0000_0000);
        @(posedge clk);
        #1;
        check("bp_first_valid", 64'(out_valid), 64'd1);
        check("bp_first_data", 64'(out_data), 64'h0005_0000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h0000_0100_0000_0000;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'h0005_0000);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        run_sum("bp_next", ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);

        // Clear after two terms; a term presented with clear is dropped.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h0000_0010_0000_0000;
            @(posedge clk);
            #1;
        end
        clear   = 1'b1;
        in_data = 64'h0000_0020_0000_0000;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_ready", 64'(in_ready), 64'd1);
        check("clr_valid", 64'(out_valid), 64'd0);
        run_sum("clr_next", ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);

        // Reset mid-sum discards the partial sum.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = BIG_POS;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("rstmid_ready", 64'(in_ready), 64'd1);
        run_sum("rstmid_next", ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);

        // Reset while holding a saturated result in OUTPUT.
        feed4(BIG_POS, BIG_POS, BIG_POS, BIG_POS);
        @(posedge clk);
        #1;
        check("rstout_pre_valid", 64'(out_valid), 64'd1);
        check("rstout_pre_sat", 64'(out_sat), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstout_valid", 64'(out_valid), 64'd0);
        check("rstout_data", 64'(out_data), 64'd0);
        check("rstout_sat", 64'(out_sat), 64'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rstout_ready", 64'(in_ready), 64'd1);
        check("rstout_stale", 64'(out_valid), 64'd0);
        run_sum("rstout_next", NEG_ONE, ONE, NEG_ONE, NEG_ONE, 32'hFFFE_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acumulador_punto_fijo.md
ACUMULADOR_PUNTO_FIJO -- requirements
Module: acumulador_punto_fijo

Interface
REQ-001 Parameter: N_TERMS, default 4, number of products summed per result (legal range 1..256).
REQ-002 Parameter: ACC_W, default 72, accumulator width in bits (SHALL be at least 64+ceil(log2(N_TERMS))+1).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous abort; discards the partial sum.
REQ-006 in_valid  input  1  in_data holds a valid product.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  64  signed two's-complement Q32.32 product from the upstream fixed-point multiplier.
REQ-009 out_valid  output  1  out_data/out_sat valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  32  signed Q16.16 rounded, saturated sum.
REQ-012 out_sat  output  1  result was clipped.

Function
REQ-013 FSM states: ACCUM, ROUND, OUTPUT; no other states reachable.
REQ-014 ACCUM: in_ready=1; a term is accepted on each edge with in_valid=1 and in_ready=1.
REQ-015 Each accepted term SHALL be sign-extended to ACC_W bits and added to acc; term counter increments by 1.
REQ-016 Accepting term number N_TERMS SHALL move the FSM to ROUND on the same edge; counter returns to 0.
REQ-017 ROUND (exactly one cycle): in_ready=0; r = (acc + 0x8000) arithmetic-shift-right 16 (round half up, Q32.32 -> Q.16).
REQ-018 Saturation: r > 0x7FFF_FFFF -> out_data=0x7FFF_FFFF, out_sat=1; r < -0x8000_0000 -> out_data=0x8000_0000, out_sat=1; else out_data=r[31:0], out_sat=0.
REQ-019 ROUND -> OUTPUT on the next edge; out_data/out_sat registered on that edge.
REQ-020 Latency: out_valid SHALL rise exactly 2 edges after the edge accepting the last term.
REQ-021 OUTPUT: out_valid=1, in_ready=0; out_data/out_sat SHALL remain stable until handshake.
REQ-022 Edge with out_valid=1 and out_ready=1: out_valid falls, acc clears to 0, FSM returns to ACCUM.
REQ-023 Throughput: one result per N_TERMS+2 cycles minimum; no input accepted during ROUND/OUTPUT.
REQ-024 clear=1 SHALL take priority over any transfer: acc=0, counter=0, out_valid=0, FSM=ACCUM on that edge; a term presented that cycle is dropped.
REQ-025 in_valid=1 while in_ready=0 SHALL leave acc and counter unchanged (upstream holds data).
REQ-026 Intermediate acc SHALL never wrap for any N_TERMS legal inputs; saturation applies only in ROUND.
REQ-027 N_TERMS=1: ACCUM->ROUND on the first accepted term.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk: FSM=ACCUM, acc=0, counter=0, out_valid=0, out_data=0, out_sat=0, in_ready=1 after release.
REQ-029 Reset asserted mid-sum or in OUTPUT SHALL discard all partial and pending results; no stale out_valid after release.
REQ-030 First term SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-031 N=4, four terms 0x0000_0001_0000_0000 (1.0) back-to-back -> out_data=0x0004_0000, out_sat=0, out_valid 2 edges after 4th accept.
REQ-032 Rounding: terms 0x8000,0,0,0 -> out_data=0x0000_0001; terms 0x7FFF,0,0,0 -> out_data=0x0000_0000.
REQ-033 Negative: four terms 0xFFFF_FFFF_0000_0000 (-1.0) -> out_data=0xFFFC_0000, out_sat=0.
REQ-034 Saturation: four terms 0x0000_7FFF_0000_0000 -> out_data=0x7FFF_FFFF, out_sat=1; four terms 0xFFFF_8000_0000_0000 -> out_data=0x8000_0000, out_sat=1 (sum exactly -131072.0 clips).
REQ-035 Backpressure: out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> next sum starts from 0.
REQ-036 clear after 2 of 4 terms, then four 1.0 terms -> out_data=0x0004_0000; rst_n=0 pulse in OUTPUT -> out_valid=0 immediately, out_data=0.
